// File: rtl/fd_scan_sequencer.sv
// Raster scan sequencer for the FAST9 corner datapath: per reference pixel it fetches
// 16 circle points, loads them into the datapath, fires one evaluate and collects the verdict.
module fd_scan_sequencer #(
  parameter int IMG_W  = 180,
  parameter int IMG_H  = 120,
  parameter int BORDER = 3,
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 15
) (
  input  logic              clock,
  input  logic              nReset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ref_addr,
  output logic              adj_valid,
  output logic [3:0]        adj_num,
  input  logic              adj_ready,
  output logic              reg_we,
  output logic [3:0]        reg_addr,
  output logic              eval,
  input  logic              res_valid,
  input  logic              res_corner,
  output logic              corner_pulse,
  output logic [ADDR_W-1:0] corner_addr,
  output logic [CNT_W-1:0]  corner_count
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0]     X_FIRST    = XW'(BORDER);
  localparam logic [XW-1:0]     X_LAST     = XW'(IMG_W - 1 - BORDER);
  localparam logic [YW-1:0]     Y_FIRST    = YW'(BORDER);
  localparam logic [YW-1:0]     Y_LAST     = YW'(IMG_H - 1 - BORDER);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(BORDER * IMG_W + BORDER);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(2 * BORDER + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EVAL, WAIT_RES, ADVANCE, DONE} state_t;

  state_t          state, next_state;
  logic [XW-1:0]   x_pos;
  logic [YW-1:0]   y_pos;
  logic            wr_pend;
  logic            pulse_q;
  logic            accept;
  logic            last_pix;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign accept   = (state == FETCH) && adj_ready && !abort;
  assign last_pix = (x_pos == X_LAST) && (y_pos == Y_LAST);

  // Every strobe is masked by abort in the cycle it arrives, so a write still in flight
  // from the last accepted request never reaches the datapath.
  assign adj_valid    = (state == FETCH) && !abort;
  assign eval         = (state == EVAL) && !abort;
  assign done         = (state == DONE) && !abort;
  assign reg_we       = wr_pend && !abort;
  assign corner_pulse = pulse_q && !abort;
  assign busy         = (state != IDLE) && (state != DONE);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = FETCH;
      FETCH:    if (accept && adj_num == 4'd15) next_state = DRAIN;
      DRAIN:    next_state = EVAL;
      EVAL:     next_state = WAIT_RES;
      WAIT_RES: if (res_valid) next_state = ADVANCE;
      ADVANCE:  next_state = last_pix ? DONE : FETCH;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      x_pos        <= '0;
      y_pos        <= '0;
      ref_addr     <= '0;
      adj_num      <= '0;
      wr_pend      <= 1'b0;
      reg_addr     <= '0;
      pulse_q      <= 1'b0;
      corner_addr  <= '0;
      corner_count <= '0;
    end else begin
      state   <= next_state;
      wr_pend <= accept;
      pulse_q <= 1'b0;
      if (accept) reg_addr <= adj_num;
      case (state)
        IDLE: if (start && !abort) begin
          ref_addr     <= ADDR_FIRST;
          x_pos        <= X_FIRST;
          y_pos        <= Y_FIRST;
          adj_num      <= '0;
          corner_count <= '0;
        end
        FETCH: if (accept) adj_num <= adj_num + 4'd1;
        WAIT_RES: if (res_valid && res_corner && !abort) begin
          pulse_q      <= 1'b1;
          corner_addr  <= ref_addr;
          corner_count <= sat_inc(corner_count);
        end
        // The last pixel keeps its address so ref_addr never leaves the valid window.
        ADVANCE: if (!abort && !last_pix) begin
          adj_num <= '0;
          if (x_pos == X_LAST) begin
            x_pos    <= X_FIRST;
            y_pos    <= y_pos + YW'(1);
            ref_addr <= ref_addr + ROW_STEP;
          end else begin
            x_pos    <= x_pos + XW'(1);
            ref_addr <= ref_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fd_scan_sequencer.sv
// Bench for fd_scan_sequencer: an 8x8 instance checked cycle by cycle from a vector table,
// and a 10x8 / 2-bit-count instance exercised with stalls, aborts, resets and saturation.
`timescale 1ns/1ps
module tb_fd_scan_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic nReset;

  logic a_start, a_abort, a_ready, a_rv, a_rc;
  logic a_busy, a_done, a_av, a_we, a_eval, a_cp;
  logic [14:0] a_ref, a_caddr, a_cnt;
  logic [3:0]  a_an, a_ra;

  fd_scan_sequencer #(.IMG_W(8), .IMG_H(8), .BORDER(3), .ADDR_W(15), .CNT_W(15)) dut_a (
    .clock(clock), .nReset(nReset), .start(a_start), .abort(a_abort),
    .busy(a_busy), .done(a_done), .ref_addr(a_ref), .adj_valid(a_av), .adj_num(a_an),
    .adj_ready(a_ready), .reg_we(a_we), .reg_addr(a_ra), .eval(a_eval),
    .res_valid(a_rv), .res_corner(a_rc), .corner_pulse(a_cp), .corner_addr(a_caddr),
    .corner_count(a_cnt));

  logic b_start, b_abort, b_ready, b_rv, b_rc;
  logic b_busy, b_done, b_av, b_we, b_eval, b_cp;
  logic [14:0] b_ref, b_caddr;
  logic [1:0]  b_cnt;
  logic [3:0]  b_an, b_ra;

  fd_scan_sequencer #(.IMG_W(10), .IMG_H(8), .BORDER(3), .ADDR_W(15), .CNT_W(2)) dut_b (
    .clock(clock), .nReset(nReset), .start(b_start), .abort(b_abort),
    .busy(b_busy), .done(b_done), .ref_addr(b_ref), .adj_valid(b_av), .adj_num(b_an),
    .adj_ready(b_ready), .reg_we(b_we), .reg_addr(b_ra), .eval(b_eval),
    .res_valid(b_rv), .res_corner(b_rc), .corner_pulse(b_cp), .corner_addr(b_caddr),
    .corner_count(b_cnt));

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Stimulus sources for dut_b: random/always-ready memory, automatic or manual datapath.
  logic rnd_mode, rnd_ready, auto_mode, auto_v, auto_c, man_v, man_c;
  logic [7:0] corner_pat;
  assign b_ready = rnd_mode ? rnd_ready : 1'b1;
  assign b_rv    = auto_mode ? auto_v : man_v;
  assign b_rc    = auto_mode ? auto_c : man_c;

  int b_ev_q[$];
  int b_cp_q[$];
  int b_done_n, b_we_n, b_ev_n, ridx, wcnt;
  logic eval_seen, eval_c, stall_prev;
  logic [3:0]  stall_num;
  logic [14:0] stall_ref;

  initial begin
    b_done_n = 0; b_we_n = 0; b_ev_n = 0; ridx = 0; wcnt = 0;
    eval_seen = 0; eval_c = 0; stall_prev = 0; stall_num = 0; stall_ref = 0;
  end

  always @(negedge clock) begin
    if (b_start && !b_abort && !b_busy && !b_done) begin
      b_ev_q.delete(); b_cp_q.delete();
      b_done_n = 0; b_we_n = 0; b_ev_n = 0; ridx = 0; wcnt = 0;
    end
    eval_seen = b_eval;
    eval_c    = b_eval & corner_pat[b_ev_n % 8];
    if (b_we) begin
      chk("reg_addr order", b_ra, ridx);
      ridx = (ridx + 1) % 16; wcnt++; b_we_n++;
    end
    if (b_eval) begin
      chk("writes per pixel", wcnt, 16);
      wcnt = 0; b_ev_n++;
      b_ev_q.push_back(int'(b_ref));
    end
    if (b_cp) b_cp_q.push_back(int'(b_caddr));
    if (b_done) b_done_n++;
    if (stall_prev && b_av) begin
      chk("adj_num held in stall", b_an, stall_num);
      chk("ref_addr held in stall", b_ref, stall_ref);
    end
    stall_prev = b_av & ~b_ready;
    stall_num  = b_an;
    stall_ref  = b_ref;
  end

  always @(posedge clock) begin
    #1;
    auto_v    = eval_seen;
    auto_c    = eval_c;
    rnd_ready = ($urandom_range(1, 0) == 1);
  end

  typedef struct {
    bit start, rv, rc;
    bit busy, av, we, ev, dn, cp;
    int an, ra, eref, cnt, caddr;
  } vec_t;
  localparam int NV = 83;
  vec_t tv[NV];

  int exp_scan[8] = '{33, 34, 35, 36, 43, 44, 45, 46};

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_b_start();
    b_start = 1'b1; cyc(); b_start = 1'b0;
  endtask

  task automatic wait_b_done(input int maxc, input string nm);
    int k = 0;
    while (b_done_n == 0 && k < maxc) begin cyc(); k++; end
    chk({nm, " done reached"}, (b_done_n != 0), 1);
  endtask

  task automatic chk_b_zero(input string nm);
    chk(nm, {b_busy, b_done, b_av, b_we, b_eval, b_cp, |b_ref, |b_caddr, |b_an, |b_ra, |b_cnt}, 0);
  endtask

  task automatic chk_scan(input string nm);
    chk({nm, " eval count"}, b_ev_n, 8);
    for (int i = 0; i < 8; i++) chk({nm, " ref_addr order"}, b_ev_q[i], exp_scan[i]);
    chk({nm, " done pulses"}, b_done_n, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pix_ref[4] = '{27, 28, 35, 36};
    bit pix_cor[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int we_s, ev_s, dn_s, k;
    int exp_cp[5] = '{33, 35, 43, 44, 46};

    for (int c = 0; c < NV; c++) begin
      int p, ph;
      tv[c] = '{default: 0};
      tv[c].eref = (c == 0) ? 0 : -1;
      if (c >= 1 && c <= 80) begin
        p  = (c - 1) / 20;
        ph = (c - 1) % 20;
        tv[c].busy = 1; tv[c].eref = pix_ref[p];
        if (ph <= 15) begin tv[c].av = 1; tv[c].an = ph; end
        if (ph >= 1 && ph <= 16) begin tv[c].we = 1; tv[c].ra = ph - 1; end
        if (ph == 17) tv[c].ev = 1;
        if (ph == 18) begin tv[c].rv = 1; tv[c].rc = pix_cor[p]; end
        if (ph == 19 && pix_cor[p]) begin tv[c].cp = 1; tv[c].caddr = pix_ref[p]; end
      end
      if (c == 81) tv[c].dn = 1;
      for (int q = 0; q < 4; q++) if (pix_cor[q] && c >= 20 * q + 20) tv[c].cnt++;
    end
    tv[0].start = 1;

    nReset = 1'b0;
    a_start = 0; a_abort = 0; a_ready = 1; a_rv = 0; a_rc = 0;
    b_start = 0; b_abort = 0; rnd_mode = 0; auto_mode = 1; man_v = 0; man_c = 0;
    corner_pat = 8'h00;
    #3;
    chk_b_zero("reset b outputs");
    chk("reset a outputs", {a_busy, a_done, a_av, a_we, a_eval, a_cp, |a_ref, |a_caddr, |a_an, |a_ra, |a_cnt}, 0);
    #20 nReset = 1'b1;
    cyc(2);

    // 8x8 frame, four pixels, corners on the first and third
    for (int c = 0; c < NV; c++) begin
      a_start = tv[c].start; a_rv = tv[c].rv; a_rc = tv[c].rc;
      @(negedge clock);
      chk("T1 busy", a_busy, tv[c].busy);
      chk("T1 adj_valid", a_av, tv[c].av);
      if (tv[c].av) chk("T1 adj_num", a_an, tv[c].an);
      chk("T1 reg_we", a_we, tv[c].we);
      if (tv[c].we) chk("T1 reg_addr", a_ra, tv[c].ra);
      chk("T1 eval", a_eval, tv[c].ev);
      chk("T1 done", a_done, tv[c].dn);
      chk("T1 corner_pulse", a_cp, tv[c].cp);
      if (tv[c].cp) chk("T1 corner_addr", a_caddr, tv[c].caddr);
      if (tv[c].eref >= 0) chk("T1 ref_addr", a_ref, tv[c].eref);
      chk("T1 corner_count", a_cnt, tv[c].cnt);
      @(posedge clock); #1;
    end

    // 10x8 frame, no corners
    corner_pat = 8'h00;
    pulse_b_start();
    wait_b_done(400, "T2");
    cyc(2);
    chk_scan("T2");
    chk("T2 corner_count", b_cnt, 0);
    chk("T2 corner pulses", b_cp_q.size(), 0);

    // Same frame with a randomly stalling memory
    rnd_mode = 1;
    pulse_b_start();
    wait_b_done(3000, "T3");
    cyc(2);
    chk_scan("T3");
    rnd_mode = 0;

    // Five corners into a 2-bit counter, plus a start while busy
    corner_pat = 8'b1011_0101;
    pulse_b_start();
    cyc(30);
    pulse_b_start();
    @(negedge clock);
    chk("T6 busy after stray start", b_busy, 1);
    cyc();
    wait_b_done(400, "T6");
    cyc(2);
    chk_scan("T6");
    chk("T6 corner pulses", b_cp_q.size(), 5);
    for (int i = 0; i < 5; i++) chk("T6 corner_addr", b_cp_q[i], exp_cp[i]);
    chk("T6 corner_count saturated", b_cnt, 3);

    // Abort in the middle of the second pixel's fetch
    corner_pat = 8'b0000_0001;
    pulse_b_start();
    k = 0;
    while (k < 100) begin
      @(negedge clock);
      if (b_ref == 15'd34 && b_av && b_an == 4'd1) break;
      k++;
    end
    chk("T4 reached second pixel", (k < 100), 1);
    @(posedge clock); #1;
    b_abort = 1'b1;
    cyc();
    b_abort = 1'b0;
    we_s = b_we_n; ev_s = b_ev_n; dn_s = b_done_n;
    @(negedge clock);
    chk("T4 idle after abort", {b_busy, b_av, b_we, b_eval, b_done}, 0);
    chk("T4 count retained", b_cnt, 1);
    cyc(40);
    chk("T4 no reg_we after abort", b_we_n, we_s);
    chk("T4 no eval after abort", b_ev_n, ev_s);
    chk("T4 no done after abort", b_done_n, dn_s);
    corner_pat = 8'h00;
    pulse_b_start();
    @(negedge clock);
    chk("T4 restart ref_addr", b_ref, 33);
    chk("T4 restart count cleared", b_cnt, 0);
    cyc();
    wait_b_done(400, "T4");
    cyc(2);
    chk_scan("T4");

    // Asynchronous reset while waiting for a verdict
    auto_mode = 0; man_v = 0; man_c = 0;
    pulse_b_start();
    k = 0;
    while (b_ev_n == 0 && k < 100) begin cyc(); k++; end
    chk("T5 reached eval", b_ev_n, 1);
    cyc(3);
    @(negedge clock);
    chk("T5 busy in wait", b_busy, 1);
    @(posedge clock);
    #2 nReset = 1'b0;
    #1 chk_b_zero("T5 outputs after async reset");
    #3 nReset = 1'b1;
    cyc();
    man_v = 1; man_c = 1;
    cyc(3);
    @(negedge clock);
    chk("T5 no corner_pulse in idle", b_cp, 0);
    chk("T5 count unchanged in idle", b_cnt, 0);
    chk("T5 busy stays low", b_busy, 0);
    man_v = 0; man_c = 0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
